// File: rtl/axi_wr_rr_ctrl.sv
// Round-robin write-channel controller: shares one AXI slave write port among NUM_MST masters,
// holding the winner from AW through all W beats to the B response.
module axi_wr_rr_ctrl #(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_MST-1:0]          m_awvalid_i,
    input  logic [NUM_MST*ADDR_W-1:0]   m_awaddr_i,
    input  logic [NUM_MST*8-1:0]        m_awlen_i,
    output logic [NUM_MST-1:0]          m_awready_o,
    input  logic [NUM_MST-1:0]          m_wvalid_i,
    input  logic [NUM_MST*DATA_W-1:0]   m_wdata_i,
    input  logic [NUM_MST*DATA_W/8-1:0] m_wstrb_i,
    input  logic [NUM_MST-1:0]          m_wlast_i,
    output logic [NUM_MST-1:0]          m_wready_o,
    output logic [NUM_MST-1:0]          m_bvalid_o,
    output logic [1:0]                  m_bresp_o,
    input  logic [NUM_MST-1:0]          m_bready_i,
    output logic                        s_awvalid_o,
    output logic [ADDR_W-1:0]           s_awaddr_o,
    output logic [7:0]                  s_awlen_o,
    input  logic                        s_awready_i,
    output logic                        s_wvalid_o,
    output logic [DATA_W-1:0]           s_wdata_o,
    output logic [DATA_W/8-1:0]         s_wstrb_o,
    output logic                        s_wlast_o,
    input  logic                        s_wready_i,
    input  logic                        s_bvalid_i,
    input  logic [1:0]                  s_bresp_i,
    output logic                        s_bready_o,
    output logic [NUM_MST-1:0]          grant_o,
    output logic                        busy_o,
    output logic                        err_wlast_o
);

    localparam int IdxW  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int StrbW = DATA_W / 8;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e              state_q;
    logic [NUM_MST-1:0]  grant_q;
    logic [IdxW-1:0]     ptr_q;
    logic [7:0]          beat_q;
    logic                err_q;

    logic [IdxW-1:0]     gidx;
    logic [IdxW-1:0]     pick_idx;
    logic [IdxW-1:0]     cand_idx;
    logic                pick_found;
    int                  cand;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            cand     = (int'(ptr_q) + i) % NUM_MST;
            cand_idx = IdxW'(cand);
            if (!pick_found && m_awvalid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant_q[i]) gidx = IdxW'(i);
        end
    end

    always_comb begin
        m_awready_o = '0;
        m_wready_o  = '0;
        m_bvalid_o  = '0;
        s_awvalid_o = 1'b0;
        s_wvalid_o  = 1'b0;
        s_wlast_o   = 1'b0;
        s_bready_o  = 1'b0;
        s_awaddr_o  = m_awaddr_i[gidx*ADDR_W +: ADDR_W];
        s_awlen_o   = m_awlen_i[gidx*8 +: 8];
        s_wdata_o   = m_wdata_i[gidx*DATA_W +: DATA_W];
        s_wstrb_o   = m_wstrb_i[gidx*StrbW +: StrbW];
        m_bresp_o   = s_bresp_i;
        unique case (state_q)
            StAddr: begin
                s_awvalid_o       = m_awvalid_i[gidx];
                m_awready_o[gidx] = s_awready_i;
            end
            StData: begin
                s_wvalid_o       = m_wvalid_i[gidx];
                m_wready_o[gidx] = s_wready_i;
                s_wlast_o        = (beat_q == 8'd0);
            end
            StResp: begin
                m_bvalid_o[gidx] = s_bvalid_i;
                s_bready_o       = m_bready_i[gidx];
            end
            default: ;
        endcase
    end

    assign grant_o     = grant_q;
    assign busy_o      = (state_q != StIdle);
    assign err_wlast_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        grant_q <= NUM_MST'(1) << pick_idx;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    if (s_awvalid_o && s_awready_i) begin
                        beat_q  <= s_awlen_o;
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (s_wvalid_o && s_wready_i) begin
                        err_q <= (m_wlast_i[gidx] != (beat_q == 8'd0));
                        if (beat_q == 8'd0) state_q <= StResp;
                        else                beat_q  <= beat_q - 8'd1;
                    end
                end
                StResp: begin
                    if (s_bvalid_i && s_bready_o) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        // Winner drops to lowest priority.
                        if (gidx == IdxW'(NUM_MST - 1)) ptr_q <= '0;
                        else                             ptr_q <= gidx + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_rr_ctrl.sv
// Directed bench for axi_wr_rr_ctrl with two masters: arbitration, burst lock, WLAST checking,
// B stall and mid-burst reset.
module tb_axi_wr_rr_ctrl;

    localparam int NUM_MST = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_MST-1:0]          m_awvalid;
    logic [NUM_MST*ADDR_W-1:0]   m_awaddr;
    logic [NUM_MST*8-1:0]        m_awlen;
    logic [NUM_MST-1:0]          m_awready;
    logic [NUM_MST-1:0]          m_wvalid;
    logic [NUM_MST*DATA_W-1:0]   m_wdata;
    logic [NUM_MST*DATA_W/8-1:0] m_wstrb;
    logic [NUM_MST-1:0]          m_wlast;
    logic [NUM_MST-1:0]          m_wready;
    logic [NUM_MST-1:0]          m_bvalid;
    logic [1:0]                  m_bresp;
    logic [NUM_MST-1:0]          m_bready;
    logic                        s_awvalid;
    logic [ADDR_W-1:0]           s_awaddr;
    logic [7:0]                  s_awlen;
    logic                        s_awready;
    logic                        s_wvalid;
    logic [DATA_W-1:0]           s_wdata;
    logic [DATA_W/8-1:0]         s_wstrb;
    logic                        s_wlast;
    logic                        s_wready;
    logic                        s_bvalid;
    logic [1:0]                  s_bresp;
    logic                        s_bready;
    logic [NUM_MST-1:0]          grant;
    logic                        busy;
    logic                        err_wlast;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    axi_wr_rr_ctrl #(
        .NUM_MST(NUM_MST),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_awvalid_i(m_awvalid),
        .m_awaddr_i (m_awaddr),
        .m_awlen_i  (m_awlen),
        .m_awready_o(m_awready),
        .m_wvalid_i (m_wvalid),
        .m_wdata_i  (m_wdata),
        .m_wstrb_i  (m_wstrb),
        .m_wlast_i  (m_wlast),
        .m_wready_o (m_wready),
        .m_bvalid_o (m_bvalid),
        .m_bresp_o  (m_bresp),
        .m_bready_i (m_bready),
        .s_awvalid_o(s_awvalid),
        .s_awaddr_o (s_awaddr),
        .s_awlen_o  (s_awlen),
        .s_awready_i(s_awready),
        .s_wvalid_o (s_wvalid),
        .s_wdata_o  (s_wdata),
        .s_wstrb_o  (s_wstrb),
        .s_wlast_o  (s_wlast),
        .s_wready_i (s_wready),
        .s_bvalid_i (s_bvalid),
        .s_bresp_i  (s_bresp),
        .s_bready_o (s_bready),
        .grant_o    (grant),
        .busy_o     (busy),
        .err_wlast_o(err_wlast)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        m_awvalid = '0;
        m_awaddr  = {32'h0000_2000, 32'h0000_1000};
        m_awlen   = {8'd3, 8'd3};
        m_wvalid  = '0;
        m_wdata   = '0;
        m_wstrb   = {4'h3, 4'hF};
        m_wlast   = '0;
        m_bready  = '0;
        s_awready = 1'b0;
        s_wready  = 1'b1;
        s_bvalid  = 1'b0;
        s_bresp   = 2'b00;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_awvalid", s_awvalid, 1'b0);
        chk("rst_err", err_wlast, 1'b0);

        // Both request: grant is registered, master 0 wins after reset.
        m_awvalid = 2'b11;
        #1;
        chk("idle_grant_reg", grant, 2'b00);
        cyc();
        chk("grant_m0", grant, 2'b01);
        chk("addr_busy", busy, 1'b1);
        chk("addr_s_awvalid", s_awvalid, 1'b1);
        chk("addr_s_awaddr", s_awaddr, 32'h0000_1000);
        chk("addr_s_awlen", s_awlen, 8'd3);
        chk("addr_awready_stall", m_awready, 2'b00);
        s_awready = 1'b1;
        #1;
        chk("addr_awready_m0", m_awready, 2'b01);
        cyc();

        // Four beats; master 0 wrongly flags WLAST on beat 2; master 1 keeps requesting.
        m_awvalid = 2'b10;
        m_wvalid  = 2'b01;
        for (int b = 0; b < 4; b++) begin
            m_wdata[31:0] = 32'hA0 + b;
            m_wlast       = (b == 1 || b == 3) ? 2'b01 : 2'b00;
            #1;
            chk("data_s_wvalid", s_wvalid, 1'b1);
            chk("data_s_wlast", s_wlast, (b == 3));
            chk("data_s_wdata", s_wdata, 32'hA0 + b);
            chk("data_s_wstrb", s_wstrb, 4'hF);
            chk("data_wready", m_wready, 2'b01);
            chk("data_m1_blocked", m_awready, 2'b00);
            cyc();
            chk("data_err_wlast", err_wlast, (b == 1));
        end
        chk("resp_no_wvalid", s_wvalid, 1'b0);
        chk("resp_no_wready", m_wready, 2'b00);
        chk("resp_grant_held", grant, 2'b01);

        // B stalled five cycles.
        m_wvalid = '0;
        m_wlast  = '0;
        m_bready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_busy", busy, 1'b1);
            chk("stall_bvalid", m_bvalid, 2'b00);
            chk("stall_s_bready", s_bready, 1'b1);
            chk("stall_err", err_wlast, 1'b0);
            cyc();
        end
        s_bvalid  = 1'b1;
        s_bresp   = 2'b10;
        m_awvalid = 2'b11;
        #1;
        chk("b_bvalid_m0", m_bvalid, 2'b01);
        chk("b_bresp", m_bresp, 2'b10);
        cyc();
        s_bvalid = 1'b0;
        m_bready = '0;
        #1;
        chk("post_b_grant", grant, 2'b00);
        chk("post_b_busy", busy, 1'b0);
        chk("post_b_bvalid", m_bvalid, 2'b00);

        // Pointer moved past master 0: master 1 wins despite both requesting.
        cyc();
        chk("grant_m1", grant, 2'b10);
        chk("m1_s_awaddr", s_awaddr, 32'h0000_2000);
        chk("m1_awready", m_awready, 2'b10);
        cyc();
        m_wvalid       = 2'b10;
        m_wdata[63:32] = 32'hBEEF;
        #1;
        chk("m1_s_wdata", s_wdata, 32'hBEEF);
        chk("m1_s_wstrb", s_wstrb, 4'h3);
        chk("m1_s_wlast_b1", s_wlast, 1'b0);
        cyc();
        chk("m1_s_wlast_b2", s_wlast, 1'b0);

        // Reset during beat 2 of master 1's burst.
        rst = 1'b1;
        cyc();
        chk("mid_rst_grant", grant, 2'b00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_s_wvalid", s_wvalid, 1'b0);
        chk("mid_rst_wready", m_wready, 2'b00);
        chk("mid_rst_awready", m_awready, 2'b00);
        chk("mid_rst_s_awvalid", s_awvalid, 1'b0);
        chk("mid_rst_s_bready", s_bready, 1'b0);
        rst       = 1'b0;
        m_wvalid  = '0;
        m_awlen   = {8'd3, 8'd0};
        cyc();
        chk("ptr_reset_grant_m0", grant, 2'b01);
        chk("single_s_awlen", s_awlen, 8'd0);

        // Single-beat burst with master WLAST missing.
        cyc();
        m_wvalid = 2'b01;
        m_wlast  = 2'b00;
        #1;
        chk("single_s_wlast", s_wlast, 1'b1);
        cyc();
        chk("single_err_wlast", err_wlast, 1'b1);
        chk("single_resp_wvalid", s_wvalid, 1'b0);
        m_wvalid = '0;
        m_bready = 2'b01;
        s_bvalid = 1'b1;
        s_bresp  = 2'b01;
        #1;
        chk("single_bvalid", m_bvalid, 2'b01);
        chk("single_bresp", m_bresp, 2'b01);
        cyc();
        s_bvalid = 1'b0;
        #1;
        chk("single_err_pulse_end", err_wlast, 1'b0);
        chk("single_idle_grant", grant, 2'b00);
        cyc();
        chk("rotate_grant_m1", grant, 2'b10);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
